cursor_ctrl: RTL



---
 rtl/cursor_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: moves a cursor over a square grid of register-bank cells from
// five debounced push buttons, and strobes RegWrite for a fixed number of
// clocks when select is pressed.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   btn_up     raw button, row - 1 (wraps)
//   btn_down   raw button, row + 1 (wraps)
//   btn_left   raw button, col - 1 (wraps)
//   btn_right  raw button, col + 1 (wraps)
//   btn_sel    raw select button, starts a write strobe
//   addrW      cursor cell address, {row, col}
//   RegWrite   increment strobe, high for WR_HOLD clocks per select press
//   busy       high whenever the FSM is not idle
module cursor_ctrl #(
  parameter int unsigned BIT_ADDR   = 4,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned WR_HOLD    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_sel,
  output logic [BIT_ADDR-1:0] addrW,
  output logic                RegWrite,
  output logic                busy
);

  localparam int unsigned NBTN   = 5;
  localparam int unsigned HALF   = BIT_ADDR / 2;
  localparam int unsigned CNT_W  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned HOLD_W = (WR_HOLD > 2) ? $clog2(WR_HOLD) : 1;

  // Button bit positions inside the packed button vectors.
  localparam int unsigned B_RIGHT = 0;
  localparam int unsigned B_LEFT  = 1;
  localparam int unsigned B_DOWN  = 2;
  localparam int unsigned B_UP    = 3;
  localparam int unsigned B_SEL   = 4;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  logic [NBTN-1:0]  raw;
  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [NBTN-1:0]  level;
  logic [NBTN-1:0]  level_prev;
  logic [NBTN-1:0]  press;
  logic [CNT_W-1:0] deb_cnt [NBTN];

  state_t           state;
  logic [HOLD_W-1:0] hold_cnt;

  logic [HALF-1:0]  row;
  logic [HALF-1:0]  col;

  assign raw = {btn_sel, btn_up, btn_down, btn_left, btn_right};
  assign row = addrW[BIT_ADDR-1:HALF];
  assign col = addrW[HALF-1:0];

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: the counter runs only while the synchronized value
  // disagrees with the accepted level; the level flips on the edge at which
  // the counter would reach DEB_CYCLES, so any shorter disagreement is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NBTN); i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          level[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // One-cycle press events on rising edges of the debounced levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_prev <= '0;
      press      <= '0;
    end else begin
      level_prev <= level;
      press      <= level & ~level_prev;
    end
  end

  // Cursor / write-strobe FSM. Press events are single-cycle, so anything
  // arriving outside IDLE, or losing the priority race, is simply dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      addrW    <= '0;
      RegWrite <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press[B_SEL]) begin
            state    <= WRITE;
            hold_cnt <= '0;
            RegWrite <= 1'b1;
            busy     <= 1'b1;
          end else if (press[B_UP]) begin
            addrW <= {row - HALF'(1), col};
          end else if (press[B_DOWN]) begin
            addrW <= {row + HALF'(1), col};
          end else if (press[B_LEFT]) begin
            addrW <= {row, col - HALF'(1)};
          end else if (press[B_RIGHT]) begin
            addrW <= {row, col + HALF'(1)};
          end
        end

        WRITE: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= RELEASE;
            RegWrite <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        RELEASE: begin
          // Wait for select to be let go so one press gives one strobe.
          if (!level[B_SEL]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          RegWrite <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
